// File: rtl/axis_out_pkg.sv
// axis_out_pkg: shared types and sizing helper for the AXIS frame output stage.
package axis_out_pkg;
   typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;
   typedef struct packed {
      logic tlast;
      logic tuser;
      logic last_frame;
   } tag_t;
   function automatic int cnt_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: two-entry skid buffer with a registered upstream ready,
// fully decoupling the input and output valid/ready handshakes.
module axis_skid_buffer
   import axis_out_pkg::*;
#(
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          in_valid,
   input  logic [PW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [PW-1:0] out_data,
   input  logic          out_ready
);
   skid_state_t state, state_nxt;
   logic [PW-1:0] skid;
   logic up, dn;

   assign up = in_valid & in_ready;
   assign dn = out_valid & out_ready;
   assign out_valid = state != EMPTY;

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   state_nxt = up ? ONE : EMPTY;
         ONE:     state_nxt = (up && !dn) ? TWO : (dn && !up) ? EMPTY : ONE;
         TWO:     state_nxt = dn ? ONE : TWO;
         default: state_nxt = EMPTY;
      endcase
      if (clear) state_nxt = EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         in_ready <= 1'b0;
         out_data <= '0;
         skid     <= '0;
      end else begin
         state    <= state_nxt;
         in_ready <= !clear && state_nxt != TWO;
         // main only changes when empty or being consumed, so a stalled beat stays stable
         if (!clear) begin
            if (state == TWO && dn) out_data <= skid;
            else if (up && (state == EMPTY || dn)) out_data <= in_data;
            if (up && state == ONE && !dn) skid <= in_data;
         end
      end
   end
endmodule

// File: rtl/axis_frame_output_stage.sv
// axis_frame_output_stage: final AXI4-Stream master; regenerates tlast/tuser from
// its own column/row counters, flags upstream tlast errors and reports frame completion.
module axis_frame_output_stage
   import axis_out_pkg::*;
#(
   parameter int AXISOUT_DATA_WIDTH = 32,
   parameter int AXISOUT_STRB_WIDTH = AXISOUT_DATA_WIDTH / 8,
   parameter int DST_IMG_WIDTH      = 3840,
   parameter int DST_IMG_HEIGHT     = 2160
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          soft_clear,
   input  logic                          ac_m_axis_tvalid,
   input  logic [AXISOUT_DATA_WIDTH-1:0] ac_m_axis_tdata,
   input  logic [AXISOUT_STRB_WIDTH-1:0] ac_m_axis_tkeep,
   input  logic                          ac_m_axis_tlast,
   output logic                          ac_m_axis_tready,
   output logic                          m_axis_tvalid,
   output logic [AXISOUT_DATA_WIDTH-1:0] m_axis_tdata,
   output logic [AXISOUT_STRB_WIDTH-1:0] m_axis_tkeep,
   output logic [AXISOUT_STRB_WIDTH-1:0] m_axis_tstrb,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tuser,
   input  logic                          m_axis_tready,
   output logic                          finnalout_m_axis_tvalid,
   output logic                          finnalout_m_axis_tready,
   output logic                          finnalout_m_axis_tlast,
   output logic                          frame_done,
   output logic                          err_tlast
);
   localparam int CW = cnt_bits(DST_IMG_WIDTH);
   localparam int RW = cnt_bits(DST_IMG_HEIGHT);
   localparam int PW = AXISOUT_DATA_WIDTH + AXISOUT_STRB_WIDTH + $bits(tag_t);

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic up, col_end, row_end;
   tag_t tag_in, tag_out;
   logic [PW-1:0] out_beat;

   assign up      = ac_m_axis_tvalid & ac_m_axis_tready;
   assign col_end = col == CW'(DST_IMG_WIDTH - 1);
   assign row_end = row == RW'(DST_IMG_HEIGHT - 1);
   assign tag_in  = {col_end, col == '0 && row == '0, col_end && row_end};

   axis_skid_buffer #(.PW(PW)) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (soft_clear),
      .in_valid (ac_m_axis_tvalid),
      .in_data  ({ac_m_axis_tdata, ac_m_axis_tkeep, tag_in}),
      .in_ready (ac_m_axis_tready),
      .out_valid(m_axis_tvalid),
      .out_data (out_beat),
      .out_ready(m_axis_tready)
   );

   assign {m_axis_tdata, m_axis_tkeep, tag_out} = out_beat;
   assign m_axis_tstrb            = m_axis_tkeep;
   assign m_axis_tlast            = tag_out.tlast;
   assign m_axis_tuser            = tag_out.tuser;
   assign finnalout_m_axis_tvalid = m_axis_tvalid;
   assign finnalout_m_axis_tready = m_axis_tready;
   assign finnalout_m_axis_tlast  = tag_out.last_frame;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col        <= '0;
         row        <= '0;
         err_tlast  <= 1'b0;
         frame_done <= 1'b0;
      end else if (soft_clear) begin
         col        <= '0;
         row        <= '0;
         err_tlast  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= m_axis_tvalid & m_axis_tready & tag_out.last_frame;
         // upstream tlast is only checked; the stream always carries the generated one
         if (up) begin
            col <= col_end ? '0 : col + 1'b1;
            if (col_end) row <= row_end ? '0 : row + 1'b1;
            if (ac_m_axis_tlast != col_end) err_tlast <= 1'b1;
         end
      end
   end
endmodule
